// File: rtl/mem_bus_pkg.sv
// Shared types for the instruction/data memory bus arbiter: FSM states, bus
// owner, transfer size encodings and the grant priority decision.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Data wins until it has taken starve_limit grants in a row over a waiting fetch.
    function automatic owner_e pick_owner(
        input logic        inst_req,
        input logic        data_req,
        input int unsigned starve_cnt,
        input int unsigned starve_limit
    );
        owner_e owner;
        if (data_req && (starve_cnt < starve_limit)) begin
            owner = OWN_DATA;
        end else if (inst_req) begin
            owner = OWN_INST;
        end else begin
            owner = OWN_DATA;
        end
        return owner;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the fetch/load-store ports, the arbiter and the shared bus.
// The arbiter uses the slave view; the surrounding CPU and memory use master.
interface mem_bus_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;

    logic        busy;

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        input  bus_rdata, bus_addr_ok, bus_data_ok,
        output busy
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        output bus_rdata, bus_addr_ok, bus_data_ok,
        input  busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch, load/store) arbiter onto one shared bus with a single
// outstanding transaction and a starvation guard for the fetch port.
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.slave  arb_if
);
    import mem_bus_pkg::*;

    localparam int unsigned   CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              addr_ok, data_ok;

    // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_INST;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        addr_ok = 1'b0;
        data_ok = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_if.inst_req || arb_if.data_req) begin
                    owner_d = pick_owner(arb_if.inst_req, arb_if.data_req, 32'(cnt_q), STARVE_LIMIT);
                    if (owner_d == OWN_INST) begin
                        wr_d    = 1'b0;
                        size_d  = SIZE_WORD;
                        addr_d  = arb_if.inst_addr;
                        wdata_d = '0;
                        cnt_d   = '0;
                    end else begin
                        wr_d    = arb_if.data_wr;
                        size_d  = arb_if.data_size;
                        addr_d  = arb_if.data_addr;
                        wdata_d = arb_if.data_wdata;
                        if (!arb_if.inst_req) begin
                            cnt_d = '0;
                        end else if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // Data can only complete together with or after its address phase.
                if (arb_if.bus_addr_ok) begin
                    addr_ok = 1'b1;
                    if (arb_if.bus_data_ok) begin
                        data_ok = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (arb_if.bus_data_ok) begin
                    data_ok = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign arb_if.inst_addr_ok = addr_ok && (owner_q == OWN_INST);
    assign arb_if.inst_data_ok = data_ok && (owner_q == OWN_INST);
    assign arb_if.data_addr_ok = addr_ok && (owner_q == OWN_DATA);
    assign arb_if.data_data_ok = data_ok && (owner_q == OWN_DATA);
    assign arb_if.inst_rdata   = arb_if.bus_rdata;
    assign arb_if.data_rdata   = arb_if.bus_rdata;

    assign arb_if.bus_req   = (state_q == ST_ADDR);
    assign arb_if.bus_wr    = wr_q;
    assign arb_if.bus_size  = size_q;
    assign arb_if.bus_addr  = addr_q;
    assign arb_if.bus_wdata = wdata_q;
    assign arb_if.busy      = (state_q != ST_IDLE);

endmodule
